// File: rtl/memory_pkg.sv
// Shared sizing and word type for the MEM-stage data memory.
package memory_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  // Tied to ADDR_W so every address maps to a word and none fall out of range.
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/memory.sv
// 32 x 32-bit data memory: synchronous write with clear-all reset, combinational gated read.
module memory
  import memory_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [ADDR_W-1:0] addrRe,
  input  logic [DATA_W-1:0] write_data,
  input  logic              MemRead,
  input  logic              MemWrite,
  output logic [DATA_W-1:0] read_data
);

  word_t r_mem [DEPTH];

  // Reset wins over a same-cycle write; clear-all reset forces a flop implementation.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (MemWrite) begin
      r_mem[addr] <= write_data;
    end
  end

  // No write-through: a same-address read sees the old word until the edge.
  assign read_data = MemRead ? r_mem[addrRe] : '0;

endmodule

// File: tb/tb_memory.sv
// Scoreboard bench for memory: a reference array predicts read_data for every probe.
module tb_memory;
  import memory_pkg::*;

  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] addrRe;
  logic [DATA_W-1:0] write_data;
  logic              MemRead;
  logic              MemWrite;
  logic [DATA_W-1:0] read_data;

  memory u_dut (
    .clk        (clk),
    .rst        (rst),
    .addr       (addr),
    .addrRe     (addrRe),
    .write_data (write_data),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .read_data  (read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  word_t model [DEPTH];
  word_t exp_q [$];
  string tag_q [$];
  int    n_pass;
  int    n_total;

  task automatic check_word(input string tag, input word_t obs, input word_t exp);
    n_total++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  // One rising edge; the model applies exactly what the DUT saw at that edge.
  task automatic tick();
    logic              s_rst, s_we;
    logic [ADDR_W-1:0] s_addr;
    word_t             s_data;
    s_rst  = rst;
    s_we   = MemWrite;
    s_addr = addr;
    s_data = write_data;
    @(posedge clk);
    #1;
    if (s_rst) begin
      for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;
    end else if (s_we) begin
      model[s_addr] = s_data;
    end
    rst      = 1'b0;
    MemWrite = 1'b0;
  endtask

  task automatic write_word(input logic [ADDR_W-1:0] a, input word_t d);
    addr       = a;
    write_data = d;
    MemWrite   = 1'b1;
    tick();
  endtask

  // Push the prediction when the probe is driven; pop it once read_data settles.
  task automatic read_check(input string tag, input logic [ADDR_W-1:0] a, input logic en);
    word_t w_obs;
    addrRe  = a;
    MemRead = en;
    exp_q.push_back(en ? model[a] : '0);
    tag_q.push_back(tag);
    #1;
    w_obs = read_data;
    check_word(tag_q.pop_front(), w_obs, exp_q.pop_front());
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_pass     = 0;
    n_total    = 0;
    rst        = 1'b0;
    addr       = '0;
    addrRe     = '0;
    write_data = '0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;

    // Fill with nonzero data so the reset sweep proves every word is cleared.
    for (int i = 0; i < int'(DEPTH); i++) begin
      write_word(ADDR_W'(i), 32'hC0DE_0000 | word_t'(i + 1));
    end
    rst = 1'b1;
    tick();
    for (int i = 0; i < int'(DEPTH); i++) begin
      read_check($sformatf("reset_clear[%0d]", i), ADDR_W'(i), 1'b1);
    end

    // Write sweep then readback, including an untouched neighbour.
    MemRead = 1'b0;
    for (int i = 0; i < 4; i++) write_word(ADDR_W'(i), word_t'(i));
    for (int i = 0; i < 5; i++) begin
      read_check($sformatf("sweep_rd[%0d]", i), ADDR_W'(i), 1'b1);
    end

    // Read gating in the same cycle.
    write_word(5'd5, 32'hDEAD_BEEF);
    read_check("gate_off", 5'd5, 1'b0);
    read_check("gate_on", 5'd5, 1'b1);
    MemRead = 1'b0;
    read_check("gate_off_again", 5'd5, 1'b0);

    // Same-address collision: old word before the edge, new word after.
    write_word(5'd7, 32'h11);
    addr       = 5'd7;
    write_data = 32'h22;
    MemWrite   = 1'b1;
    read_check("collide_before", 5'd7, 1'b1);
    tick();
    read_check("collide_after", 5'd7, 1'b1);

    // Both enables low: stored data holds, output forced to zero.
    read_check("idle_zero", 5'd7, 1'b0);

    // Reset priority over a same-cycle write, observed through the read port.
    rst        = 1'b1;
    addr       = 5'd3;
    write_data = 32'hFFFF_FFFF;
    MemWrite   = 1'b1;
    read_check("rst_pre_edge", 5'd3, 1'b1);
    tick();
    read_check("rst_prio_mem3", 5'd3, 1'b1);
    read_check("rst_clears_mem5", 5'd5, 1'b1);

    // Boundary address and isolation of neighbours.
    write_word(5'd30, 32'h3030_3030);
    write_word(5'd0, 32'h0000_0A0A);
    write_word(5'd31, 32'hA5A5_A5A5);
    read_check("top_addr31", 5'd31, 1'b1);
    read_check("iso_addr30", 5'd30, 1'b1);
    read_check("iso_addr0", 5'd0, 1'b1);

    // Random writes with simultaneous reads, then a full-array comparison.
    for (int k = 0; k < 40; k++) begin
      addr       = ADDR_W'($urandom_range(0, DEPTH - 1));
      write_data = $urandom;
      MemWrite   = ($urandom_range(0, 3) != 0);
      read_check($sformatf("rand_rd[%0d]", k), ADDR_W'($urandom_range(0, DEPTH - 1)),
                 1'($urandom_range(0, 1)));
      tick();
    end
    for (int i = 0; i < int'(DEPTH); i++) begin
      read_check($sformatf("final[%0d]", i), ADDR_W'(i), 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
